square16: RTL and testbench

Sequential 16-bit integer squarer, the inverse of the `sqrt32` datapath: it takes a 16-bit root `y` and produces the 32-bit square `x = y*y` with a shift-add iteration, one multiplier bit per clock. It uses the same reset-to-start / `rdy` completion protocol as `sqrt32`, so the two can share one bench style. A `sqrt32` result can be fed straight back through it for self-checking.

---
 rtl/square16.sv | 113 +++++++++++
 tb/tb_square16.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/square16.sv
// Sequential 16x16 shift-add squarer, one multiplier bit per clock, rdy-level handshake.
// Optional root check (x_ref input, ok output, CHECK state) enabled by SQUARE16_CHECK_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_LOAD  | operand captured while reset is high; first iteration on release
// S_RUN   | one shift-add iteration per edge, 16 in total
// S_CHECK | compare x_ref against the square (enabled build only)
// S_DONE  | result held, rdy high until the next reset
module square16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] y,
`ifdef SQUARE16_CHECK_EN
  input  logic [31:0] x_ref,
  output logic        ok,
`endif
  output logic        rdy,
  output logic [31:0] x
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic [31:0] add_term;

`ifdef SQUARE16_CHECK_EN
  logic [31:0] xref_q;
  logic        ok_q, ok_d;
  logic [32:0] diff;
  logic [32:0] two_y;

  // After 16 shifts mcand holds y<<16, so y<<1 sits in its top 17 bits.
  assign two_y = {16'b0, mcand_q[31:15]};
  assign diff  = {1'b0, xref_q} - {1'b0, acc_q};
`endif

  assign add_term = mplier_q[0] ? mcand_q : 32'd0;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rdy_d    = rdy_q;
`ifdef SQUARE16_CHECK_EN
    ok_d     = ok_q;
`endif
    case (state_q)
      S_LOAD, S_RUN: begin
        acc_d    = acc_q + add_term;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        state_d  = S_RUN;
        if (cnt_q == 5'd15) begin
`ifdef SQUARE16_CHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          rdy_d   = 1'b1;
`endif
        end
      end
`ifdef SQUARE16_CHECK_EN
      S_CHECK: begin
        ok_d    = ~diff[32] && (diff <= two_y);
        rdy_d   = 1'b1;
        state_d = S_DONE;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      mcand_q  <= {16'b0, y};
      mplier_q <= y;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      rdy_q    <= 1'b0;
`ifdef SQUARE16_CHECK_EN
      xref_q   <= x_ref;
      ok_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
`ifdef SQUARE16_CHECK_EN
      ok_q     <= ok_d;
`endif
    end
  end

  assign x   = acc_q;
  assign rdy = rdy_q;
`ifdef SQUARE16_CHECK_EN
  assign ok  = ok_q;
`endif

endmodule

// File: tb/tb_square16.sv
// Randomized self-checking bench for square16; reference is plain integer arithmetic.
// Covers both builds; the root-check cases are active when SQUARE16_CHECK_EN is defined.
module tb_square16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] y = 16'd0;
  logic        rdy;
  logic [31:0] x;
`ifdef SQUARE16_CHECK_EN
  logic [31:0] x_ref = 32'd0;
  logic        ok;
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  int n_checks = 0;
  int n_errors = 0;

  square16 dut (
    .clk   (clk),
    .reset (reset),
    .y     (y),
`ifdef SQUARE16_CHECK_EN
    .x_ref (x_ref),
    .ok    (ok),
`endif
    .rdy   (rdy),
    .x     (x)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sq(input logic [15:0] v);
    longint s;
    s = longint'(v) * longint'(v);
    return s[31:0];
  endfunction

  function automatic logic ok_model(input logic [15:0] v, input logic [31:0] xr);
    longint lo, hi;
    lo = longint'(v) * longint'(v);
    hi = (longint'(v) + 1) * (longint'(v) + 1);
    return (longint'(xr) >= lo) && (longint'(xr) < hi);
  endfunction

  // Called just after reset release at a negedge; E0 is the next posedge.
  task automatic wait_done(input logic [15:0] yv, input logic [31:0] xr, input string tag);
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk);
      #1;
      y = 16'($urandom);
`ifdef SQUARE16_CHECK_EN
      x_ref = $urandom;
`endif
      if (k < LAT - 1) check({tag, "_rdy_early"}, {31'b0, rdy}, 32'd0);
    end
    check({tag, "_rdy"}, {31'b0, rdy}, 32'd1);
    check({tag, "_x"}, x, sq(yv));
`ifdef SQUARE16_CHECK_EN
    check({tag, "_ok"}, {31'b0, ok}, {31'b0, ok_model(yv, xr)});
`else
    if (xr != 32'd0) ;
`endif
  endtask

  task automatic run(input logic [15:0] yv, input logic [31:0] xr, input string tag);
    @(negedge clk);
    reset = 1'b1;
    y = yv;
`ifdef SQUARE16_CHECK_EN
    x_ref = xr;
`endif
    @(negedge clk);
    check({tag, "_rst_rdy"}, {31'b0, rdy}, 32'd0);
    check({tag, "_rst_x"}, x, 32'd0);
`ifdef SQUARE16_CHECK_EN
    check({tag, "_rst_ok"}, {31'b0, ok}, 32'd0);
`endif
    reset = 1'b0;
    wait_done(yv, xr, tag);
  endtask

  initial begin
    logic [15:0] rv;
    logic [15:0] pulse_vals [5];
    pulse_vals[0] = 16'd0;
    pulse_vals[1] = 16'd1;
    pulse_vals[2] = 16'd2;
    pulse_vals[3] = 16'd1000;
    pulse_vals[4] = 16'd65535;

    run(16'd0,     32'd0,          "y0");
    run(16'd65535, 32'hFFFE0001,   "ymax");
    run(16'd46340, 32'd2147395600, "y46340");
    run(16'd1,     32'd1,          "y1");

    // Abort mid-run, restart with y = 3.
    @(negedge clk);
    reset = 1'b1;
    y = 16'd1234;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_run_rdy", {31'b0, rdy}, 32'd0);
    end
    reset = 1'b1;
    y = 16'd3;
    @(negedge clk);
    check("abort_rdy", {31'b0, rdy}, 32'd0);
    check("abort_x", x, 32'd0);
    reset = 1'b0;
    wait_done(16'd3, 32'd9, "abort_restart");

    // Result must hold while y toggles.
    run(16'd65535, 32'hFFFE0001, "hold_start");
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      y = 16'($urandom);
      if (k % 25 == 0) begin
        check("hold_rdy", {31'b0, rdy}, 32'd1);
        check("hold_x", x, 32'hFFFE0001);
      end
    end

`ifdef SQUARE16_CHECK_EN
    run(16'd4, 32'd24, "chk_4_24");
    run(16'd4, 32'd25, "chk_4_25");
    run(16'd5, 32'd24, "chk_5_24");
    run(16'd0, 32'd0,  "chk_0_0");
    for (int i = 0; i < 8; i++) begin
      rv = 16'($urandom);
      run(rv, sq(rv) + 32'($urandom_range(0, 2)) * 32'(rv) - 32'($urandom_range(0, 1)), "chk_rand");
    end
`endif

    for (int i = 0; i < 20; i++) begin
      rv = 16'($urandom);
      run(rv, sq(rv), "rand");
    end

    // Reset pulses of 35 time units, not aligned to the clock.
    for (int i = 0; i < 5; i++) begin
      int c;
      @(negedge clk);
      #2;
      reset = 1'b1;
      y = pulse_vals[i];
`ifdef SQUARE16_CHECK_EN
      x_ref = sq(pulse_vals[i]);
`endif
      #35;
      reset = 1'b0;
      c = 0;
      while (!rdy && c < 40) begin
        @(posedge clk);
        #1;
        c++;
      end
      check("pulse_rdy", {31'b0, rdy}, 32'd1);
      check("pulse_lat", 32'(c), 32'(LAT));
      check("pulse_x", x, sq(pulse_vals[i]));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
